// File: rtl/shift_register_pkg.sv
// ---------------------------------------------------------------------------
// shift_register_pkg
//   Shared definitions for the universal shift register:
//     mode_e         3-bit operation codes (HOLD, SHR, SHL, ROR, ROL, LOAD,
//                    CLEAR, ASR)
//     is_shift_mode  true for the modes that advance the step counter
//     counter_width  width of the step counter for a given steps-per-word
// ---------------------------------------------------------------------------
package shift_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_ROR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_ASR   = 3'b111
    } mode_e;

    function automatic logic is_shift_mode(input mode_e m);
        return (m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR});
    endfunction

    // Counter must be at least one bit wide even when it only ever holds 0.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_step_counter.sv
// ---------------------------------------------------------------------------
// shift_step_counter
//   Counts shift steps within a word and pulses done for one cycle when the
//   N-th step of a word has been taken. LOAD/CLEAR restart the word.
//
//   Ports:
//     clk      in   1    clock
//     rst_n    in   1    synchronous active-low reset
//     step     in   1    a shift step is taken this cycle
//     restart  in   1    LOAD/CLEAR taken this cycle; wins over step
//     count    out  CW   steps taken in the current word (0 .. N-1)
//     done     out  1    registered one-cycle word-complete pulse
// ---------------------------------------------------------------------------
module shift_step_counter
    import shift_register_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = counter_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          restart,
    output logic [CW-1:0] count,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_count;
    logic          r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (restart) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (step) begin
            if (r_count == LAST) begin
                r_count <= '0;
                r_done  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_done  <= 1'b0;
            end
        end else begin
            r_done  <= 1'b0;
        end
    end

    assign count = r_count;
    assign done  = r_done;

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
//   W-bit multi-mode shift register moving S bits per enabled step
//   (shift right/left, rotate, arithmetic right, parallel load, clear), with
//   a step counter that pulses done after each full word of N = W/S steps.
//
//   Ports:
//     clk        in   1    clock
//     rst_n      in   1    synchronous active-low reset
//     en         in   1    step enable; 0 holds all state
//     mode       in   3    operation select (mode_e codes)
//     sin_hi     in   S    lane entering the MSB end on SHR
//     sin_lo     in   S    lane entering the LSB end on SHL
//     load_data  in   W    parallel data for LOAD
//     out        out  W    register contents
//     sout_lo    out  S    out[S-1:0]
//     sout_hi    out  S    out[W-1:W-S]
//     count      out  CW   steps taken in the current word
//     done       out  1    one-cycle word-complete pulse
// ---------------------------------------------------------------------------
module universal_shift_register
    import shift_register_pkg::*;
#(
    parameter int W = 8,
    parameter int S = 1,
    localparam int N  = W / S,
    localparam int CW = counter_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [S-1:0]  sin_hi,
    input  logic [S-1:0]  sin_lo,
    input  logic [W-1:0]  load_data,
    output logic [W-1:0]  out,
    output logic [S-1:0]  sout_lo,
    output logic [S-1:0]  sout_hi,
    output logic [CW-1:0] count,
    output logic          done
);

    mode_e         w_mode;
    logic [W-1:0]  r_data;
    logic [W-1:0]  w_next;
    logic          w_step;
    logic          w_restart;

    assign w_mode = mode_e'(mode);

    always_comb begin
        w_next = r_data;
        if (en) begin
            case (w_mode)
                MODE_HOLD:  w_next = r_data;
                MODE_SHR:   w_next = {sin_hi, r_data[W-1:S]};
                MODE_SHL:   w_next = {r_data[W-S-1:0], sin_lo};
                MODE_ROR:   w_next = {r_data[S-1:0], r_data[W-1:S]};
                MODE_ROL:   w_next = {r_data[W-S-1:0], r_data[W-1:W-S]};
                MODE_LOAD:  w_next = load_data;
                MODE_CLEAR: w_next = '0;
                MODE_ASR:   w_next = {{S{r_data[W-1]}}, r_data[W-1:S]};
                default:    w_next = r_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_next;
        end
    end

    assign w_step    = en & is_shift_mode(w_mode);
    assign w_restart = en & ((w_mode == MODE_LOAD) | (w_mode == MODE_CLEAR));

    shift_step_counter #(
        .N  (N),
        .CW (CW)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (w_step),
        .restart (w_restart),
        .count   (count),
        .done    (done)
    );

    assign out     = r_data;
    assign sout_lo = r_data[S-1:0];
    assign sout_hi = r_data[W-1:W-S];

endmodule

// File: tb/tb_universal_shift_register.sv
// Three instances (W=8/S=1, W=8/S=2, W=16/S=4) share one stimulus stream;
// each is compared every cycle with an arithmetic model, and the directed
// scenarios add fixed expectations on the instance they target.
module tb_universal_shift_register;

    localparam int HOLD = 0, SHR = 1, SHL = 2, ROR = 3, ROL = 4,
                   LOAD = 5, CLEAR = 6, ASR = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  mode;
    logic [3:0]  sh;
    logic [3:0]  sl;
    logic [15:0] ld;

    logic [7:0]  out0;  logic       slo0, shi0;  logic [2:0] cnt0;  logic done0;
    logic [7:0]  out1;  logic [1:0] slo1, shi1;  logic [1:0] cnt1;  logic done1;
    logic [15:0] out2;  logic [3:0] slo2, shi2;  logic [1:0] cnt2;  logic done2;

    int n_checks = 0;
    int n_pass   = 0;

    int cfg_w [3] = '{8, 8, 16};
    int cfg_s [3] = '{1, 2, 4};
    int m_out [3];
    int m_cnt [3];
    int m_done[3];

    always #5 clk = ~clk;

    universal_shift_register #(.W(8), .S(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sin_hi(sh[0]), .sin_lo(sl[0]), .load_data(ld[7:0]),
        .out(out0), .sout_lo(slo0), .sout_hi(shi0), .count(cnt0), .done(done0)
    );

    universal_shift_register #(.W(8), .S(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sin_hi(sh[1:0]), .sin_lo(sl[1:0]), .load_data(ld[7:0]),
        .out(out1), .sout_lo(slo1), .sout_hi(shi1), .count(cnt1), .done(done1)
    );

    universal_shift_register #(.W(16), .S(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sin_hi(sh), .sin_lo(sl), .load_data(ld),
        .out(out2), .sout_lo(slo2), .sout_hi(shi2), .count(cnt2), .done(done2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Next word computed with masks and integer shifts.
    function automatic int ref_next(int w, int s, int md, int o, int hi, int lo, int d);
        int wm = (1 << w) - 1;
        int sm = (1 << s) - 1;
        case (md)
            SHR:     return ((hi & sm) << (w - s)) | (o >> s);
            SHL:     return ((o << s) | (lo & sm)) & wm;
            ROR:     return ((o & sm) << (w - s)) | (o >> s);
            ROL:     return ((o << s) & wm) | (o >> (w - s));
            LOAD:    return d & wm;
            CLEAR:   return 0;
            ASR:     return (o >> s) | (((o >> (w - 1)) & 1) != 0 ? (sm << (w - s)) : 0);
            default: return o;
        endcase
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n = cfg_w[k] / cfg_s[k];
            if (!rst_n) begin
                m_out[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
            end else if (!en || mode == HOLD) begin
                m_done[k] = 0;
            end else if (mode == LOAD || mode == CLEAR) begin
                m_out[k]  = ref_next(cfg_w[k], cfg_s[k], mode, m_out[k], sh, sl, ld);
                m_cnt[k]  = 0;
                m_done[k] = 0;
            end else begin
                m_out[k]  = ref_next(cfg_w[k], cfg_s[k], mode, m_out[k], sh, sl, ld);
                m_done[k] = (m_cnt[k] == n - 1) ? 1 : 0;
                m_cnt[k]  = (m_cnt[k] + 1) % n;
            end
        end
    endtask

    task automatic cmp_one(input int k, input int o, input int c, input int d,
                           input int lo, input int hi);
        int w = cfg_w[k];
        int s = cfg_s[k];
        chk($sformatf("out%0d", k),  o,  m_out[k]);
        chk($sformatf("cnt%0d", k),  c,  m_cnt[k]);
        chk($sformatf("done%0d", k), d,  m_done[k]);
        chk($sformatf("slo%0d", k),  lo, m_out[k] & ((1 << s) - 1));
        chk($sformatf("shi%0d", k),  hi, m_out[k] >> (w - s));
    endtask

    // Drive at the falling edge, advance one rising edge, then compare.
    task automatic cyc(input logic r, input logic e, input int md,
                       input logic [3:0] h, input logic [3:0] l, input logic [15:0] d);
        rst_n = r; en = e; mode = 3'(md); sh = h; sl = l; ld = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_one(0, out0, cnt0, done0, slo0, shi0);
        cmp_one(1, out1, cnt1, done1, slo1, shi1);
        cmp_one(2, out2, cnt2, done2, slo2, shi2);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = '0; sh = '0; sl = '0; ld = '0;
        for (int k = 0; k < 3; k++) begin
            m_out[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
        end
        @(negedge clk);

        // reset, then a disabled LOAD must not change anything
        cyc(1'b0, 1'b1, LOAD, 4'hF, 4'hF, 16'hFFFF);
        chk("rst_out", out0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_done", done0, 0);
        repeat (3) cyc(1'b1, 1'b0, LOAD, 4'h0, 4'h0, 16'h00FF);
        chk("en0_out", out0, 0);

        // SHR of 0xA5 with ones coming in
        cyc(1'b1, 1'b1, LOAD, 4'h0, 4'h0, 16'h00A5);
        chk("load_a5", out0, 8'hA5);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b1, SHR, 4'hF, 4'h0, 16'h0);
            chk($sformatf("shr_done_%0d", i), done0, (i == 8) ? 1 : 0);
        end
        chk("shr_out", out0, 8'hFF);
        chk("shr_cnt", cnt0, 0);
        cyc(1'b1, 1'b1, HOLD, 4'h0, 4'h0, 16'h0);
        chk("hold_done", done0, 0);

        // 2-bit lanes: four ROLs restore the word, then one ROR
        cyc(1'b1, 1'b1, LOAD, 4'h0, 4'h0, 16'h0081);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b1, ROL, 4'h0, 4'h0, 16'h0);
            chk($sformatf("rol_done_%0d", i), done1, (i == 4) ? 1 : 0);
        end
        chk("rol_out", out1, 8'h81);
        cyc(1'b1, 1'b1, ROR, 4'h0, 4'h0, 16'h0);
        chk("ror_out", out1, 8'h60);

        // ASR sign fill, then CLEAR
        cyc(1'b1, 1'b1, LOAD, 4'h0, 4'h0, 16'h0080);
        repeat (3) cyc(1'b1, 1'b1, ASR, 4'h0, 4'h0, 16'h0);
        chk("asr_out", out0, 8'hF0);
        cyc(1'b1, 1'b1, CLEAR, 4'h0, 4'h0, 16'h0);
        chk("clr_out", out0, 0);
        chk("clr_cnt", cnt0, 0);
        chk("clr_done", done0, 0);

        // LOAD restarts the word; reset mid-word discards it
        repeat (5) cyc(1'b1, 1'b1, SHL, 4'h0, 4'hF, 16'h0);
        chk("shl5_cnt", cnt0, 5);
        cyc(1'b1, 1'b1, LOAD, 4'h0, 4'h0, 16'h003C);
        chk("ld_cnt", cnt0, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b1, SHL, 4'h0, 4'hF, 16'h0);
            chk($sformatf("shl_nodone_%0d", i), done0, 0);
        end
        chk("shl6_cnt", cnt0, 6);
        cyc(1'b0, 1'b1, SHL, 4'h0, 4'hF, 16'h0);
        chk("midrst_cnt", cnt0, 0);
        chk("midrst_out", out0, 0);

        // 16-bit deserializer from nibbles
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b1, SHL, 4'h0, 4'(i), 16'h0);
        end
        chk("des_done", done2, 1);
        chk("des_out", out2, 16'h1234);
        chk("des_shi", shi2, 4'h1);
        chk("des_slo", slo2, 4'h4);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
